lisa_autobaud: RTL
==================

# lisa_autobaud

Automatic baud-rate detector for the LISA debug UART. Sits upstream of `debug_brg`: it watches the serial receive line for a host sync character 0x55 ('U'), measures its bit period in `clk` cycles and loads `baud_div`/`baud_set` into the baud generator. `lisa_tx8n` and `lisa_rx8n` then run at the host's rate without a firmware-configured divider.

## Interface
Parameters:
- `CNT_W`, 15: width of the total-measure counter.
- `IDLE_MIN`, 64: minimum consecutive synchronized-high `clk` cycles before a start edge is accepted.

Ports:
- `clk`  in  1  system clock.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `arm`  in  1  one-cycle pulse that starts or restarts detection; ignored while measuring.
- `rxd`  in  1  asynchronous serial line, idle high.
- `baud_div`  out  7  divider for `debug_brg`; `baud_ref` period = `baud_div`+1 clocks, 16 ticks per bit.
- `baud_set`  out  1  one-cycle pulse when a new `baud_div` is valid.
- `locked`  out  1  level; a valid divider has been loaded.
- `err`  out  1  one-cycle pulse on a rejected measurement.

## Operation
- `rxd` passes a 2-flop synchronizer; a falling edge is `sync_d1 & ~sync_d0`.
- For 0x55 sent LSB-first, 5 falling edges occur: start, d1, d3, d5, d7. The span from edge 1 to edge 5 is exactly 8 bit periods. Each gap between consecutive edges is 2 bit periods.
- States:
  - IDLE: waits for `arm`.
  - WAIT_IDLE: counts consecutive high samples. Any low clears the count. At `IDLE_MIN` it moves to WAIT_START.
  - WAIT_START: the first falling edge clears `total` and `intv`, sets edge_cnt=1 and moves to MEASURE.
  - MEASURE: `total` and `intv` increment every cycle. On each falling edge, `intv` is checked (see Configuration), edge_cnt increments and `intv` clears. The edge that makes edge_cnt=5 moves to CALC.
  - CALC: computes `r = (total + 64) >> 7`.
    - If `r` is in 2..128: `baud_div` <= `r`-1, `baud_set` pulses, `locked` <= 1, next state LOCKED.
    - Otherwise: `err` pulses and the block returns to WAIT_IDLE.
  - LOCKED: holds `baud_div`. `arm` clears `locked` and moves to WAIT_IDLE. `baud_div` keeps its old value until the next successful CALC.
- Overflow: when `total` reaches all-ones in MEASURE, `err` pulses and the block returns to WAIT_IDLE. The counter never wraps.
- `arm` in IDLE or LOCKED is accepted. In any other state it is ignored.
- Reset (asynchronous) at any point, including mid-measure, forces state IDLE and all counters to 0.

## Timing
- Reset values: `baud_div`=0, `baud_set`=0, `locked`=0, `err`=0, state IDLE.
- Input latency: `rxd` to edge detect is 2 cycles. The offset is identical for all edges, so the measured span is exact.
- `baud_set`, `locked` and `err` are registered. They assert in the cycle after CALC is entered, i.e. 2 cycles after the 5th synchronized edge.
- `baud_set` and `err` never assert in the same cycle.
- `baud_div` changes only in the same cycle that `baud_set` is high.
- A falling edge in the same cycle as the overflow condition: overflow wins.

## Configuration
- `LISA_AUTOBAUD_CHECK_EN` defined:
  - The first gap is stored as `i1` (13 bits).
  - Each later gap must satisfy |gap − `i1`| ≤ `i1`>>2.
  - A failing gap pulses `err` in the cycle after the edge and returns to WAIT_IDLE. This rejects characters other than 0x55 and glitches.
- Undefined: no gap register and no check; only range and overflow errors apply.

## Structure
- Package `lisa_autobaud_pkg`:
  - state enum `ab_state_t` (IDLE, WAIT_IDLE, WAIT_START, MEASURE, CALC, LOCKED);
  - constants `AB_SYNC_EDGES`=5, `AB_OVS_SHIFT`=7, `AB_ROUND`=64, `AB_R_MIN`=2, `AB_R_MAX`=128.
- Sub-module `lisa_sync_fedge`: 2-flop synchronizer plus falling-edge detector, exposing `sync_out` and `fall`.

## Test plan
- Nominal: reset, pulse `arm`, hold `rxd` high 100 cycles, send 0x55 at 320 clk/bit. Required: `baud_div`=19, one `baud_set` pulse, `locked`=1, no `err`.
- Rounding boundary at 330 clk/bit: `total`=2640, `r`=21. Required: `baud_div`=20.
- With CHECK_EN, send 0x0D at 320 clk/bit (uneven gaps). Required: `err` pulse, `locked` stays 0. A subsequent 0x55 then locks with `baud_div`=19.
- Range: send 0x55 at 8 clk/bit (`r`=1). Required: `err`. Hold `rxd` low after a start edge until `total` saturates. Required: one `err`, return to WAIT_IDLE.
- Reset mid-MEASURE after 3 edges. Required: all outputs 0 and state IDLE. Edges without `arm` produce no response.
- Rearm while locked, then send 0x55 at 160 clk/bit. Required: `locked` drops on `arm`, `baud_div` stays 19 until the new `baud_set`, then `baud_div`=9.

Source files
------------

// File: rtl/lisa_autobaud_pkg.sv
// lisa_autobaud_pkg: shared state encoding, constants and helpers for the
// LISA debug-UART automatic baud-rate detector.
package lisa_autobaud_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_IDLE,
    WAIT_START,
    MEASURE,
    CALC,
    LOCKED
  } ab_state_t;

  // 0x55 sent LSB-first yields five falling edges spanning eight bit periods
  localparam int AB_SYNC_EDGES = 5;
  // 8 bits * 16 ticks per bit = 128 ticks across the measured span
  localparam int AB_OVS_SHIFT  = 7;
  localparam int AB_ROUND      = 64;
  localparam int AB_R_MIN      = 2;
  localparam int AB_R_MAX      = 128;
  // Width of the stored first-gap reference used by the gap checker
  localparam int AB_GAP_W      = 13;

  // True when a gap lies within a quarter of the reference gap
  function automatic logic gap_within(input logic [AB_GAP_W-1:0] gap,
                                      input logic [AB_GAP_W-1:0] i1);
    logic [AB_GAP_W-1:0] diff;
    diff = (gap > i1) ? (gap - i1) : (i1 - gap);
    return diff <= (i1 >> 2);
  endfunction

endpackage

// File: rtl/lisa_sync_fedge.sv
// lisa_sync_fedge: two-flop synchronizer for the asynchronous serial line
// plus a falling-edge detector on the synchronized signal. Flops reset to
// the idle-high level so leaving reset never fakes an edge.
module lisa_sync_fedge (
  input  logic clk,
  input  logic rst_n,
  input  logic rxd,
  output logic sync_out,
  output logic fall
);

  logic sync_meta_reg;
  logic sync_d0_reg;
  logic sync_d1_reg;

  // Synchronizer chain followed by one delay stage for edge detection
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_meta_reg <= 1'b1;
      sync_d0_reg   <= 1'b1;
      sync_d1_reg   <= 1'b1;
    end else begin
      sync_meta_reg <= rxd;
      sync_d0_reg   <= sync_meta_reg;
      sync_d1_reg   <= sync_d0_reg;
    end
  end

  assign sync_out = sync_d0_reg;
  assign fall     = sync_d1_reg & ~sync_d0_reg;

endmodule

// File: rtl/lisa_autobaud.sv
// lisa_autobaud: measures the bit period of a 0x55 sync character on rxd
// and loads a 16x oversampling divider into the debug baud generator.
// Optional build macro: LISA_AUTOBAUD_CHECK_EN enables per-gap consistency
// checking against the first measured gap (rejects non-0x55 and glitches).
module lisa_autobaud
  import lisa_autobaud_pkg::*;
#(
  parameter int CNT_W    = 15,
  parameter int IDLE_MIN = 64
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       arm,
  input  logic       rxd,
  output logic [6:0] baud_div,
  output logic       baud_set,
  output logic       locked,
  output logic       err
);

  localparam int IDLE_W = $clog2(IDLE_MIN + 1);
  localparam int R_W    = CNT_W - AB_OVS_SHIFT + 1;

  logic sync_out;
  logic fall;

  lisa_sync_fedge u_sync (
    .clk      (clk),
    .rst_n    (rst_n),
    .rxd      (rxd),
    .sync_out (sync_out),
    .fall     (fall)
  );

  ab_state_t         state_reg,    state_next;
  logic [IDLE_W-1:0] idle_cnt_reg, idle_cnt_next;
  logic [CNT_W-1:0]  total_reg,    total_next;
  logic [CNT_W-1:0]  intv_reg,     intv_next;
  logic [2:0]        edge_cnt_reg, edge_cnt_next;
  logic [6:0]        baud_div_reg, baud_div_next;
  logic              baud_set_reg, baud_set_next;
  logic              locked_reg,   locked_next;
  logic              err_reg,      err_next;

  logic              overflow;
  logic [R_W-1:0]    r_val;
  logic              r_in_range;
  logic              gap_fail;

  // Counter pinned at all-ones means the span no longer fits
  assign overflow   = (total_reg == {CNT_W{1'b1}});
  // Rounded divide of the 8-bit span by 128 ticks
  assign r_val      = R_W'(({1'b0, total_reg} + (CNT_W+1)'(AB_ROUND)) >> AB_OVS_SHIFT);
  assign r_in_range = (r_val >= R_W'(AB_R_MIN)) && (r_val <= R_W'(AB_R_MAX));

`ifdef LISA_AUTOBAUD_CHECK_EN
  logic [AB_GAP_W-1:0] i1_reg, i1_next;
  logic [CNT_W-1:0]    gap;
  logic [AB_GAP_W-1:0] gap_sat;

  // intv counts from zero after an edge, so the gap is one more than intv
  assign gap      = intv_reg + CNT_W'(1);
  assign gap_sat  = (gap > CNT_W'(2**AB_GAP_W - 1)) ? {AB_GAP_W{1'b1}} : AB_GAP_W'(gap);
  // Only edges after the reference gap has been captured are checked
  assign gap_fail = (edge_cnt_reg != 3'd1) && !gap_within(gap_sat, i1_reg);
`else
  assign gap_fail = 1'b0;
`endif

  // All registers: async clear to IDLE with every counter and output at zero
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= IDLE;
      idle_cnt_reg <= '0;
      total_reg    <= '0;
      intv_reg     <= '0;
      edge_cnt_reg <= '0;
      baud_div_reg <= '0;
      baud_set_reg <= 1'b0;
      locked_reg   <= 1'b0;
      err_reg      <= 1'b0;
`ifdef LISA_AUTOBAUD_CHECK_EN
      i1_reg       <= '0;
`endif
    end else begin
      state_reg    <= state_next;
      idle_cnt_reg <= idle_cnt_next;
      total_reg    <= total_next;
      intv_reg     <= intv_next;
      edge_cnt_reg <= edge_cnt_next;
      baud_div_reg <= baud_div_next;
      baud_set_reg <= baud_set_next;
      locked_reg   <= locked_next;
      err_reg      <= err_next;
`ifdef LISA_AUTOBAUD_CHECK_EN
      i1_reg       <= i1_next;
`endif
    end
  end

  // Next-state and datapath updates for the detection sequence
  always_comb begin
    state_next    = state_reg;
    idle_cnt_next = idle_cnt_reg;
    total_next    = total_reg;
    intv_next     = intv_reg;
    edge_cnt_next = edge_cnt_reg;
    baud_div_next = baud_div_reg;
    baud_set_next = 1'b0;
    locked_next   = locked_reg;
    err_next      = 1'b0;
`ifdef LISA_AUTOBAUD_CHECK_EN
    i1_next       = i1_reg;
`endif

    case (state_reg)
      IDLE: begin
        if (arm) begin
          state_next    = WAIT_IDLE;
          idle_cnt_next = '0;
        end
      end

      WAIT_IDLE: begin
        if (!sync_out) begin
          idle_cnt_next = '0;
        end else if (idle_cnt_reg == IDLE_W'(IDLE_MIN - 1)) begin
          idle_cnt_next = '0;
          state_next    = WAIT_START;
        end else begin
          idle_cnt_next = idle_cnt_reg + IDLE_W'(1);
        end
      end

      WAIT_START: begin
        if (fall) begin
          total_next    = '0;
          intv_next     = '0;
          edge_cnt_next = 3'd1;
          state_next    = MEASURE;
        end
      end

      MEASURE: begin
        if (overflow) begin
          // Saturated span takes priority over any coincident edge
          err_next      = 1'b1;
          idle_cnt_next = '0;
          state_next    = WAIT_IDLE;
        end else begin
          total_next = total_reg + CNT_W'(1);
          intv_next  = intv_reg + CNT_W'(1);
          if (fall) begin
            intv_next     = '0;
            edge_cnt_next = edge_cnt_reg + 3'd1;
`ifdef LISA_AUTOBAUD_CHECK_EN
            if (edge_cnt_reg == 3'd1) begin
              i1_next = gap_sat;
            end
`endif
            if (gap_fail) begin
              err_next      = 1'b1;
              idle_cnt_next = '0;
              state_next    = WAIT_IDLE;
            end else if (edge_cnt_reg == 3'(AB_SYNC_EDGES - 1)) begin
              state_next = CALC;
            end
          end
        end
      end

      CALC: begin
        if (r_in_range) begin
          baud_div_next = 7'(r_val - R_W'(1));
          baud_set_next = 1'b1;
          locked_next   = 1'b1;
          state_next    = LOCKED;
        end else begin
          err_next      = 1'b1;
          idle_cnt_next = '0;
          state_next    = WAIT_IDLE;
        end
      end

      LOCKED: begin
        if (arm) begin
          locked_next   = 1'b0;
          idle_cnt_next = '0;
          state_next    = WAIT_IDLE;
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign baud_div = baud_div_reg;
  assign baud_set = baud_set_reg;
  assign locked   = locked_reg;
  assign err      = err_reg;

endmodule
